// File: rtl/hdlverifier_trigger_unit.sv
// -----------------------------------------------------------------------------
// hdlverifier_trigger_unit
//
// Programmable trigger-condition generator that sits directly in front of the
// data-capture block. Probe samples are registered (stage 1), checked against
// a masked compare / edge condition, qualified by a hit count and a
// post-trigger holdoff, and emitted (stage 2) as a single-cycle trigger. The
// trigger stays cycle-aligned with the delayed data and clock enable.
//
// Handshake: clk_enable is a plain sample-valid qualifier with no back-pressure.
// A sample is consumed on every clk edge where clk_enable = 1. The pipeline
// advances on every clk whatever clk_enable is, so data_out, clk_enable_out and
// trigger_out always describe the sample presented two cycles earlier.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   clk_enable        sample valid
//   data_in           probe data
//   run               arm request; its rising edge latches the configuration
//   trig_value        compare value
//   trig_mask         1 = bit takes part in the compare / change detect
//   trig_mode         0 match, 1 mismatch, 2 enter-match, 3 leave-match,
//                     4 any-change, 5-7 disabled
//   trig_count        qualifying hits per trigger (0 behaves as 1)
//   holdoff           enabled samples ignored after each trigger
//   data_out          data_in delayed by 2 cycles
//   clk_enable_out    clk_enable delayed by 2 cycles
//   trigger_out       one-cycle trigger aligned with data_out
//   armed             FSM is in ARMED
//   hit_count         current qualified-hit count
// -----------------------------------------------------------------------------
module hdlverifier_trigger_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [2:0]            trig_mode,
    input  logic [CNT_WIDTH-1:0]  trig_count,
    input  logic [CNT_WIDTH-1:0]  holdoff,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  clk_enable_out,
    output logic                  trigger_out,
    output logic                  armed,
    output logic [CNT_WIDTH-1:0]  hit_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Stage 1
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic                  en1_q, en1_d;
    logic                  live1_q, live1_d;
    logic                  run_d1_q, run_d1_d;

    // Latched configuration
    logic [DATA_WIDTH-1:0] cfg_value_q, cfg_value_d;
    logic [DATA_WIDTH-1:0] cfg_mask_q, cfg_mask_d;
    logic [2:0]            cfg_mode_q, cfg_mode_d;
    logic [CNT_WIDTH-1:0]  cfg_count_q, cfg_count_d;
    logic [CNT_WIDTH-1:0]  cfg_holdoff_q, cfg_holdoff_d;

    // Previous-sample state for edge modes
    logic [DATA_WIDTH-1:0] prev_d_q, prev_d_d;
    logic                  prev_match_q, prev_match_d;
    logic                  prev_valid_q, prev_valid_d;

    // FSM and counters
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  hold_q, hold_d;

    // Stage 2
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  en_out_q, en_out_d;
    logic                  trig_out_q, trig_out_d;

    // Decision intermediates
    logic                  arm_edge;
    logic                  eval;
    logic                  match;
    logic                  change;
    logic                  hit;
    logic [CNT_WIDTH-1:0]  target;
    logic [CNT_WIDTH-1:0]  hit_inc;

    always_comb begin
        arm_edge = run & ~run_d1_q;

        // Stage 1. live1 marks samples presented while the FSM was already
        // out of IDLE, so the sample sitting in the arm cycle is never
        // evaluated: the first evaluable sample is the one after the edge.
        data1_d  = data_in;
        en1_d    = clk_enable;
        live1_d  = (state_q != ST_IDLE);
        run_d1_d = run;

        cfg_value_d   = arm_edge ? trig_value : cfg_value_q;
        cfg_mask_d    = arm_edge ? trig_mask  : cfg_mask_q;
        cfg_mode_d    = arm_edge ? trig_mode  : cfg_mode_q;
        cfg_count_d   = arm_edge ? trig_count : cfg_count_q;
        cfg_holdoff_d = arm_edge ? holdoff    : cfg_holdoff_q;

        // A decision taken while run = 0 can never trigger.
        eval   = en1_q & live1_q & run & (state_q != ST_IDLE);
        match  = ((data1_q & cfg_mask_q) == (cfg_value_q & cfg_mask_q));
        change = |((data1_q ^ prev_d_q) & cfg_mask_q);

        hit = 1'b0;
        case (cfg_mode_q)
            3'd0:    hit = match;
            3'd1:    hit = ~match;
            3'd2:    hit = prev_valid_q & match & ~prev_match_q;
            3'd3:    hit = prev_valid_q & ~match & prev_match_q;
            3'd4:    hit = prev_valid_q & change;
            default: hit = 1'b0;
        endcase

        target  = (cfg_count_q == '0) ? CNT_ONE : cfg_count_q;
        hit_inc = hit_q + CNT_ONE;

        // History tracks every enabled evaluated sample, holdoff included.
        prev_d_d     = prev_d_q;
        prev_match_d = prev_match_q;
        prev_valid_d = prev_valid_q;
        if (arm_edge) begin
            prev_valid_d = 1'b0;
        end else if (eval) begin
            prev_d_d     = data1_q;
            prev_match_d = match;
            prev_valid_d = 1'b1;
        end

        state_d    = state_q;
        hit_d      = hit_q;
        hold_d     = hold_q;
        trig_out_d = 1'b0;

        if (!run) begin
            state_d = ST_IDLE;
            hit_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hit_d  = '0;
                    hold_d = '0;
                    if (arm_edge) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (eval && hit) begin
                        if (hit_inc == target) begin
                            trig_out_d = 1'b1;
                            hit_d      = '0;
                            if (cfg_holdoff_q != '0) begin
                                state_d = ST_HOLDOFF;
                                hold_d  = cfg_holdoff_q;
                            end
                        end else begin
                            hit_d = hit_inc;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (eval) begin
                        if (hold_q <= CNT_ONE) begin
                            state_d = ST_ARMED;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hit_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end

        data_out_d = data1_q;
        en_out_d   = en1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1_q       <= '0;
            en1_q         <= 1'b0;
            live1_q       <= 1'b0;
            run_d1_q      <= 1'b0;
            cfg_value_q   <= '0;
            cfg_mask_q    <= '0;
            cfg_mode_q    <= '0;
            cfg_count_q   <= '0;
            cfg_holdoff_q <= '0;
            prev_d_q      <= '0;
            prev_match_q  <= 1'b0;
            prev_valid_q  <= 1'b0;
            state_q       <= ST_IDLE;
            hit_q         <= '0;
            hold_q        <= '0;
            data_out_q    <= '0;
            en_out_q      <= 1'b0;
            trig_out_q    <= 1'b0;
        end else begin
            data1_q       <= data1_d;
            en1_q         <= en1_d;
            live1_q       <= live1_d;
            run_d1_q      <= run_d1_d;
            cfg_value_q   <= cfg_value_d;
            cfg_mask_q    <= cfg_mask_d;
            cfg_mode_q    <= cfg_mode_d;
            cfg_count_q   <= cfg_count_d;
            cfg_holdoff_q <= cfg_holdoff_d;
            prev_d_q      <= prev_d_d;
            prev_match_q  <= prev_match_d;
            prev_valid_q  <= prev_valid_d;
            state_q       <= state_d;
            hit_q         <= hit_d;
            hold_q        <= hold_d;
            data_out_q    <= data_out_d;
            en_out_q      <= en_out_d;
            trig_out_q    <= trig_out_d;
        end
    end

    assign data_out       = data_out_q;
    assign clk_enable_out = en_out_q;
    assign trigger_out    = trig_out_q;
    assign armed          = (state_q == ST_ARMED);
    assign hit_count      = hit_q;

endmodule
